binary_morph_frame_ctrl: RTL

//   Frame sequencer for the 3x3 binary morphology window engine (linebuffer + 3x3 matrix + decision).
//   The engine only advances on its enable and has a window delay of one line plus two pixels.

---
 rtl/binary_morph_frame_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/binary_morph_frame_ctrl.sv
// Frame sequencer around a 3x3 binary morphology engine: admits one frame, flushes the
// engine with pad pixels, drops priming outputs and emits a bordered W*H frame.
module binary_morph_frame_ctrl #(
    parameter int unsigned    DW       = 24,
    parameter int unsigned    IMG_W    = 640,
    parameter int unsigned    IMG_H    = 480,
    parameter int unsigned    WIN_DLY  = IMG_W + 2,
    parameter logic [DW-1:0]  PAD_VAL  = '0,
    parameter logic [DW-1:0]  BORD_VAL = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] s_data,
    input  logic          s_valid,
    input  logic          s_sof,
    output logic          s_ready,
    output logic [DW-1:0] eng_data,
    output logic          eng_en,
    input  logic [DW-1:0] eng_out_data,
    output logic [DW-1:0] m_data,
    output logic          m_valid,
    output logic          m_sof,
    output logic          m_eol,
    output logic          busy,
    output logic          frame_done,
    output logic          sof_err
);

    localparam int unsigned NPIX = IMG_W * IMG_H;
    localparam int unsigned KW   = $clog2(NPIX + WIN_DLY + 1);
    localparam int unsigned CW   = $clog2(IMG_W);
    localparam int unsigned RW   = $clog2(IMG_H);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_e;

    state_e          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic            cap_vld_q, cap_vld_d;
    logic            cap_keep_q, cap_keep_d;
    logic [DW-1:0]   m_data_q, m_data_d;
    logic            m_valid_q, m_valid_d;
    logic            m_sof_q, m_sof_d;
    logic            m_eol_q, m_eol_d;
    logic            frame_done_q, frame_done_d;
    logic            sof_err_q, sof_err_d;
    logic            xfer;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            k_q          <= '0;
            col_q        <= '0;
            row_q        <= '0;
            cap_vld_q    <= 1'b0;
            cap_keep_q   <= 1'b0;
            m_data_q     <= '0;
            m_valid_q    <= 1'b0;
            m_sof_q      <= 1'b0;
            m_eol_q      <= 1'b0;
            frame_done_q <= 1'b0;
            sof_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            col_q        <= col_d;
            row_q        <= row_d;
            cap_vld_q    <= cap_vld_d;
            cap_keep_q   <= cap_keep_d;
            m_data_q     <= m_data_d;
            m_valid_q    <= m_valid_d;
            m_sof_q      <= m_sof_d;
            m_eol_q      <= m_eol_d;
            frame_done_q <= frame_done_d;
            sof_err_q    <= sof_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (xfer && s_sof) state_d = RUN;
            RUN:     if (xfer && k_q == KW'(NPIX - 1)) state_d = FLUSH;
            FLUSH:   if (k_q == KW'(NPIX + WIN_DLY - 1)) state_d = DONE;
            DONE:    if (!cap_vld_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s_ready  = (state_q == IDLE) || (state_q == RUN);
        busy     = (state_q != IDLE);
        xfer     = s_valid && s_ready;
        eng_en   = 1'b0;
        eng_data = '0;
        case (state_q)
            IDLE:    eng_en = xfer && s_sof;
            RUN:     eng_en = xfer;
            FLUSH:   eng_en = 1'b1;
            default: eng_en = 1'b0;
        endcase
        if (state_q == FLUSH) eng_data = PAD_VAL;
        else if (eng_en)      eng_data = s_data;
    end

    // k holds the index of the current enable; the capture stage runs one cycle behind it.
    always_comb begin
        k_d = k_q;
        if (state_q == IDLE) k_d = eng_en ? KW'(1) : '0;
        else if (eng_en)     k_d = k_q + KW'(1);

        cap_vld_d    = eng_en;
        cap_keep_d   = eng_en && (state_q != IDLE) && (k_q >= KW'(WIN_DLY));
        col_d        = col_q;
        row_d        = row_q;
        m_valid_d    = cap_keep_q;
        m_data_d     = '0;
        m_sof_d      = 1'b0;
        m_eol_d      = 1'b0;
        if (cap_keep_q) begin
            if (row_q == '0 || row_q == RW'(IMG_H - 1) || col_q == '0 || col_q == CW'(IMG_W - 1))
                m_data_d = BORD_VAL;
            else
                m_data_d = eng_out_data;
            m_sof_d = (row_q == '0) && (col_q == '0);
            m_eol_d = (col_q == CW'(IMG_W - 1));
            if (col_q == CW'(IMG_W - 1)) begin
                col_d = '0;
                row_d = (row_q == RW'(IMG_H - 1)) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
        frame_done_d = (state_q == DONE) && !cap_vld_q;
        sof_err_d    = sof_err_q || ((state_q == RUN) && xfer && s_sof);
    end

    assign m_data     = m_data_q;
    assign m_valid    = m_valid_q;
    assign m_sof      = m_sof_q;
    assign m_eol      = m_eol_q;
    assign frame_done = frame_done_q;
    assign sof_err    = sof_err_q;

endmodule
